// File: rtl/uart_debug_tx.sv
// uart_debug_tx: FIFO-buffered debug UART transmitter, 8N1 by default.
// Defining UART_DEBUG_TX_PARITY_EN adds an even-parity bit, giving 8E1 framing.
module uart_debug_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [7:0]                    wr_byte,
    input  logic                          wr_valid,
    output logic                          wr_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          tx_busy,
    output logic                          tx_serial
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef UART_DEBUG_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          wr_full_q, overflow_q;
    state_t        state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          tx_q, busy_q;
    logic          push, pop, not_empty, bit_done;

    assign not_empty = count_q != '0;
    assign bit_done  = baud_q == BW'(CLKS_PER_BIT - 1);
    assign push      = wr_valid && !wr_full_q;
    assign pop       = not_empty && (state_q == IDLE || (state_q == STOP && bit_done));
    assign count_d   = count_q + CW'(push) - CW'(pop);

    assign wr_full    = wr_full_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign tx_busy    = busy_q;
    assign tx_serial  = tx_q;

    // Byte storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_byte;
    end

    // FIFO bookkeeping; a write while full is dropped even if a pop frees a slot.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wr_full_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_q + AW'(push);
            rd_ptr_q   <= rd_ptr_q + AW'(pop);
            count_q    <= count_d;
            wr_full_q  <= count_d == CW'(FIFO_DEPTH);
            overflow_q <= overflow_q | (wr_valid & wr_full_q);
        end
    end

    // Frame serialiser; the baud counter restarts at every bit boundary so frames never drift.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            baud_q <= (state_q == IDLE || bit_done) ? '0 : baud_q + BW'(1);
            case (state_q)
                IDLE: if (not_empty) begin
                    shift_q <= mem_q[rd_ptr_q];
                    tx_q    <= 1'b0;
                    busy_q  <= 1'b1;
                    state_q <= START;
                end
                START: if (bit_done) begin
                    tx_q    <= shift_q[0];
                    bit_q   <= '0;
                    state_q <= DATA;
                end
                DATA: if (bit_done) begin
                    if (bit_q == 3'd7) begin
`ifdef UART_DEBUG_TX_PARITY_EN
                        tx_q    <= ^shift_q;
                        state_q <= PARITY;
`else
                        tx_q    <= 1'b1;
                        state_q <= STOP;
`endif
                    end else begin
                        bit_q <= bit_q + 3'd1;
                        tx_q  <= shift_q[bit_q + 3'd1];
                    end
                end
`ifdef UART_DEBUG_TX_PARITY_EN
                PARITY: if (bit_done) begin
                    tx_q    <= 1'b1;
                    state_q <= STOP;
                end
`endif
                STOP: if (bit_done) begin
                    if (not_empty) begin
                        shift_q <= mem_q[rd_ptr_q];
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_debug_tx.sv
// tb_uart_debug_tx: randomized bench for uart_debug_tx against a queue/frame-level model.
module tb_uart_debug_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;
`ifdef UART_DEBUG_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * CPB;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] wr_byte;
    logic       wr_valid;
    logic       wr_full, overflow, tx_busy, tx_serial;
    logic [$clog2(DEPTH):0] fifo_count;

    uart_debug_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .wr_byte(wr_byte), .wr_valid(wr_valid),
        .wr_full(wr_full), .fifo_count(fifo_count), .overflow(overflow),
        .tx_busy(tx_busy), .tx_serial(tx_serial)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  mq[$];
    logic        m_active, m_ovf;
    int          m_t;
    logic [10:0] m_frame;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b);
`ifdef UART_DEBUG_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b0, 1'b1, b, 1'b0};
`endif
    endfunction

    task automatic model_reset();
        mq.delete();
        m_active = 1'b0;
        m_ovf    = 1'b0;
        m_t      = 0;
        m_frame  = '1;
    endtask

    task automatic model_step(input logic v, input logic [7:0] b);
        logic full, ne;
        full = mq.size() == DEPTH;
        ne   = mq.size() != 0;
        if (m_active) begin
            m_t++;
            if (m_t == FL) begin
                if (ne) begin
                    m_frame = mk_frame(mq.pop_front());
                    m_t = 0;
                end else begin
                    m_active = 1'b0;
                end
            end
        end else if (ne) begin
            m_frame  = mk_frame(mq.pop_front());
            m_t      = 0;
            m_active = 1'b1;
        end
        if (v) begin
            if (full) m_ovf = 1'b1;
            else mq.push_back(b);
        end
    endtask

    task automatic check_outputs();
        check("tx_serial", tx_serial, m_active ? m_frame[m_t / CPB] : 1'b1);
        check("tx_busy", tx_busy, m_active);
        check("fifo_count", fifo_count, mq.size());
        check("wr_full", wr_full, mq.size() == DEPTH);
        check("overflow", overflow, m_ovf);
    endtask

    task automatic tick(input logic v, input logic [7:0] b);
        wr_valid = v;
        wr_byte  = b;
        @(posedge clk);
        model_step(v, b);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drain();
        for (int i = 0; i < 4000 && (m_active || mq.size() != 0); i++) tick(1'b0, 8'h00);
    endtask

    initial begin
        resetn   = 1'b0;
        wr_valid = 1'b0;
        wr_byte  = 8'h00;
        model_reset();
        repeat (5) begin
            @(negedge clk);
            check_outputs();
        end
        resetn = 1'b1;
        repeat (100) tick(1'b0, 8'h00);
        tick(1'b1, 8'hA5);
        drain();
        repeat (3) tick(1'b0, 8'h00);
        tick(1'b1, 8'h55);
        tick(1'b1, 8'h0F);
        tick(1'b1, 8'hFF);
        drain();
        repeat (2000) tick($urandom_range(0, 99) < 2, 8'($urandom));
        drain();
`ifdef UART_DEBUG_TX_PARITY_EN
        tick(1'b1, 8'h07);
        drain();
        tick(1'b1, 8'h03);
        drain();
`endif
        for (int i = 1; i <= 10; i++) tick(1'b1, 8'(i * 17));
        check("overflow_sticky", overflow, 1'b1);
        check("full_after_burst", wr_full, 1'b1);
        drain();
        check("overflow_kept", overflow, 1'b1);
        repeat (1500) tick($urandom_range(0, 99) < 20, 8'($urandom));
        drain();
        tick(1'b1, 8'h3C);
        tick(1'b1, 8'($urandom));
        tick(1'b1, 8'($urandom));
        for (int i = 0; i < 200 && !(m_active && m_t == 4 * CPB + 1); i++) tick(1'b0, 8'h00);
        check("reached_bit3", m_active && m_t == 4 * CPB + 1, 1'b1);
        #2 resetn = 1'b0;
        model_reset();
        #1;
        check("async_tx_high", tx_serial, 1'b1);
        check("async_count0", fifo_count, 0);
        check_outputs();
        repeat (2) begin
            @(negedge clk);
            check_outputs();
        end
        resetn = 1'b1;
        repeat (60) tick(1'b0, 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
